// File: rtl/risc_spm_pkg.sv
// Shared types and constants for the RISC_SPM memory unit.
package risc_spm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_e;

    localparam int WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/risc_spm_mem_array.sv
// Storage for the memory unit: DEPTH words, synchronous write, combinational read.
module risc_spm_mem_array #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    // Separate read address lets a zero-wait read land on the same edge a write commits.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/risc_spm_mem_unit.sv
// RISC_SPM memory unit: req/ready/done handshake with configurable wait states and range check.
// States: IDLE (waiting for req) | WAIT (counting wait states) | DONE (one-cycle completion).
module risc_spm_mem_unit
    import risc_spm_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     write,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     ready,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     err
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);
    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE = WAIT_CNT_WIDTH'(1);

    mem_state_e state, state_next;
    logic [WAIT_CNT_WIDTH-1:0] cnt, cnt_next;

    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_data;
    logic                     lat_write;
    logic                     lat_oob;

    logic                     accept;
    logic                     req_oob;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     rd_oob;
    logic                     rd_write;
    logic [DATA_WIDTH-1:0]    arr_rdata;
    logic [DATA_WIDTH-1:0]    rd_data;

    assign ready   = !rst && (state != WAIT);
    assign accept  = req && ready;
    assign req_oob = !({1'b0, address} < DEPTH_W);
    assign done    = (state == DONE);
    assign err     = (state == DONE) && lat_oob;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (accept) begin
            state_next = (WAIT_STATES == 0) ? DONE : WAIT;
            cnt_next   = WAIT_LOAD;
        end else begin
            case (state)
                WAIT: begin
                    cnt_next = cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) begin
                        state_next = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // With zero wait states a request enters DONE on its own acceptance edge, so the
    // incoming address is the one to read; otherwise the latched one.
    assign commit   = (state == DONE) && lat_write && !lat_oob;
    assign rd_addr  = accept ? address : lat_addr;
    assign rd_oob   = accept ? req_oob : lat_oob;
    assign rd_write = accept ? write : lat_write;
    assign rd_data  = (commit && (lat_addr == rd_addr)) ? lat_data : arr_rdata;

    risc_spm_mem_array #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .INIT_VALUE   (INIT_VALUE)
    ) u_array (
        .clk  (clk),
        .we   (commit),
        .waddr(lat_addr),
        .wdata(lat_data),
        .raddr(rd_addr),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            lat_oob   <= 1'b0;
            data_out  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_addr  <= address;
                lat_data  <= data_in;
                lat_write <= write;
                lat_oob   <= req_oob;
            end
            if ((state_next == DONE) && !rd_write) begin
                data_out <= rd_oob ? '0 : rd_data;
            end
        end
    end

endmodule
